// File: rtl/riscv_fetch_if.sv
// Fetch-stage bus: instruction-memory request/response channels and the decode handoff.
// master = fetch stage, slave = memory/decoder side.
interface riscv_fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_pc_o,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, inst_o, inst_pc_o,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready
  );
endinterface

// File: rtl/riscv_fetch.sv
// Instruction fetch stage: owns the PC, issues imem word reads, buffers instructions for decode.
// FETCH_MISALIGN_CHECK_EN: misaligned redirect targets set a sticky misalign_o and halt fetching.
module riscv_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  riscv_fetch_if.master bus,
  input  logic          redirect_valid,
  input  logic [31:0]   redirect_pc,
  output logic          misalign_o
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  logic [31:0]      pc_q, pc_d;
  logic             run_q;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  fill_ptr_q, fill_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [31:0]      buf_pc_q   [DEPTH];
  logic [31:0]      buf_inst_q [DEPTH];
  logic [DEPTH-1:0] buf_filled_q;

  logic [IdxW-1:0]  wr_idx, fill_idx, rd_idx;
  logic [PtrW-1:0]  alloc_cnt, unfilled_cnt;
  logic [PtrW:0]    occupancy;
  logic             halted, req_fire, rsp_keep, pop;

  assign wr_idx       = wr_ptr_q[IdxW-1:0];
  assign fill_idx     = fill_ptr_q[IdxW-1:0];
  assign rd_idx       = rd_ptr_q[IdxW-1:0];
  assign alloc_cnt    = wr_ptr_q - rd_ptr_q;
  assign unfilled_cnt = wr_ptr_q - fill_ptr_q;

  assign bus.inst_valid = (alloc_cnt != '0) & buf_filled_q[rd_idx];
  assign bus.inst_o     = buf_inst_q[rd_idx];
  assign bus.inst_pc_o  = buf_pc_q[rd_idx];
  assign pop            = bus.inst_valid & bus.inst_ready;

  // A same-cycle pop frees its slot for the new request, keeping one fetch per cycle at DEPTH=2.
  assign occupancy = {1'b0, alloc_cnt} + {1'b0, drop_cnt_q} - {{PtrW{1'b0}}, pop};

  assign bus.imem_req_valid = run_q & ~halted & ~redirect_valid & (occupancy < DepthCnt);
  assign bus.imem_req_addr  = pc_q;
  assign req_fire           = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_keep           = bus.imem_rsp_valid & (drop_cnt_q == '0) & ~redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    wr_ptr_d   = wr_ptr_q;
    fill_ptr_d = fill_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    drop_cnt_d = drop_cnt_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      wr_ptr_d   = '0;
      fill_ptr_d = '0;
      rd_ptr_d   = '0;
      // Every in-flight request becomes stale; a response landing now is already one of them.
      drop_cnt_d = drop_cnt_q + unfilled_cnt - PtrW'(bus.imem_rsp_valid);
    end else begin
      if (req_fire) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (bus.imem_rsp_valid) begin
        if (drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - PtrW'(1);
        else                  fill_ptr_d = fill_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      run_q      <= 1'b0;
      wr_ptr_q   <= '0;
      fill_ptr_q <= '0;
      rd_ptr_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      pc_q       <= pc_d;
      run_q      <= 1'b1;
      wr_ptr_q   <= wr_ptr_d;
      fill_ptr_q <= fill_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_pc_q     <= '{default: '0};
      buf_inst_q   <= '{default: '0};
      buf_filled_q <= '0;
    end else if (!redirect_valid) begin
      if (req_fire) begin
        buf_pc_q[wr_idx]     <= pc_q;
        buf_filled_q[wr_idx] <= 1'b0;
      end
      if (rsp_keep) begin
        buf_inst_q[fill_idx]   <= bus.imem_rsp_data;
        buf_filled_q[fill_idx] <= 1'b1;
      end
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              misalign_q <= 1'b0;
    else if (redirect_valid) misalign_q <= (redirect_pc[1:0] != 2'b00);
  end

  assign halted     = misalign_q;
  assign misalign_o = misalign_q;
`else
  logic unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign halted               = 1'b0;
  assign misalign_o           = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// Bench for riscv_fetch: in-order latency-configurable memory model plus a scoreboard of
// expected (pc, inst) pairs popped on every decode handshake.
module tb_riscv_fetch;
  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int unsigned due;
  } mem_req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        misalign;

  mem_req_t    mem_q[$];
  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned mem_lat = 1;
  int unsigned req_cnt = 0;
  int unsigned pop_cnt = 0;
  bit          const_data = 1'b1;
  bit          mon_en = 1'b0;
  int          n_cmp = 0;
  int          n_mis = 0;

  riscv_fetch_if bus ();

  riscv_fetch #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_o     (misalign)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : (a ^ 32'hC3A5_0000);
  endfunction

  // Memory: records handshakes mid-cycle, answers in order mem_lat cycles later.
  initial begin
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
        mem_q.push_back('{addr: bus.imem_req_addr, data: mem_data(bus.imem_req_addr),
                          due: cyc + mem_lat});
        req_cnt++;
      end
      @(posedge clk);
      #1;
      if (!rst_n) mem_q.delete();
      if (rst_n && mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_q[0].data;
        void'(mem_q.pop_front());
      end else begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
      end
    end
  end

  // Scoreboard: decode handshakes outside redirect cycles must match the expected stream.
  initial forever begin
    @(negedge clk);
    if (rst_n && mon_en && !redirect_valid && bus.inst_valid && bus.inst_ready) begin
      pop_cnt++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_mis++;
        $display("FAIL sb_extra: got pc=%h inst=%h, want no instruction",
                 bus.inst_pc_o, bus.inst_o);
      end else if (bus.inst_pc_o !== exp_q[0].pc || bus.inst_o !== exp_q[0].inst) begin
        n_mis++;
        $display("FAIL sb_inst: got pc=%h inst=%h, want pc=%h inst=%h",
                 bus.inst_pc_o, bus.inst_o, exp_q[0].pc, exp_q[0].inst);
        void'(exp_q.pop_front());
      end else begin
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000, want finish");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: base + 32'(4 * i), inst: mem_data(base + 32'(4 * i))});
    end
  endtask

  // Leaves the bench one cycle into reset release (run not yet set).
  task automatic do_reset(input int unsigned lat, input bit cdata);
    rst_n              = 1'b0;
    mon_en             = 1'b0;
    exp_q.delete();
    mem_lat            = lat;
    const_data         = cdata;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b1;
    repeat (3) next_cycle();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset(1, 1'b1);
    bus.inst_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_mis++; $display("FAIL release_no_req: got %b, want 0", bus.imem_req_valid);
    end
    next_cycle();
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== RESET_PC) begin
      n_mis++;
      $display("FAIL first_req: got valid=%b addr=%h, want valid=1 addr=%h",
               bus.imem_req_valid, bus.imem_req_addr, RESET_PC);
    end
    repeat (5) next_cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0 || misalign !== 1'b0) begin
      n_mis++;
      $display("FAIL reset_flags: got req=%b inst=%b mis=%b, want 0 0 0",
               bus.imem_req_valid, bus.inst_valid, misalign);
    end
    n_cmp++;
    if (bus.imem_req_addr !== RESET_PC) begin
      n_mis++; $display("FAIL reset_addr: got %h, want %h", bus.imem_req_addr, RESET_PC);
    end
    n_cmp++;
    if (bus.inst_o !== 32'h0 || bus.inst_pc_o !== 32'h0) begin
      n_mis++;
      $display("FAIL reset_inst: got inst=%h pc=%h, want 0 0", bus.inst_o, bus.inst_pc_o);
    end
  endtask

  task automatic test_stream();
    int unsigned pop_base;
    do_reset(1, 1'b1);
    bus.inst_ready = 1'b1;
    push_exp(32'h0, 20);
    pop_base = pop_cnt;
    mon_en   = 1'b1;
    for (int j = 0; j < 10; j++) begin
      next_cycle();
      @(negedge clk);
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'(4 * j)) begin
        n_mis++;
        $display("FAIL stream_req[%0d]: got valid=%b addr=%h, want valid=1 addr=%h",
                 j, bus.imem_req_valid, bus.imem_req_addr, 32'(4 * j));
      end
      n_cmp++;
      if (bus.inst_valid !== (j >= 2)) begin
        n_mis++;
        $display("FAIL stream_valid[%0d]: got %b, want %b", j, bus.inst_valid, (j >= 2));
      end
    end
    mon_en = 1'b0;
    n_cmp++;
    if (pop_cnt - pop_base != 8) begin
      n_mis++; $display("FAIL stream_pops: got %0d, want 8", pop_cnt - pop_base);
    end
  endtask

  task automatic test_backpressure();
    int unsigned req_base;
    do_reset(1, 1'b0);
    req_base = req_cnt;
    repeat (8) next_cycle();
    @(negedge clk);
    n_cmp++;
    if (req_cnt - req_base != DEPTH || bus.imem_req_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL bp_full: got reqs=%0d valid=%b, want reqs=%0d valid=0",
               req_cnt - req_base, bus.imem_req_valid, DEPTH);
    end
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.inst_pc_o !== 32'h0) begin
      n_mis++;
      $display("FAIL bp_head: got valid=%b pc=%h, want valid=1 pc=0",
               bus.inst_valid, bus.inst_pc_o);
    end
    next_cycle();
    push_exp(32'h0, 8);
    mon_en         = 1'b1;
    bus.inst_ready = 1'b1;
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) next_cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL bp_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_inflight();
    do_reset(3, 1'b0);
    repeat (3) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    bus.inst_ready = 1'b1;
    push_exp(32'h100, 8);
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.imem_req_valid !== 1'b0) begin
      n_mis++; $display("FAIL inflight_redir_req: got %b, want 0", bus.imem_req_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.drop_cnt_q !== 2'd2 || bus.inst_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL inflight_drop: got drop=%0d valid=%b, want drop=2 valid=0",
               dut.drop_cnt_q, bus.inst_valid);
    end
    for (int k = 0; k < 60 && exp_q.size() != 0; k++) next_cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL inflight_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_redirect_collide();
    do_reset(1, 1'b0);
    bus.inst_ready = 1'b1;
    repeat (6) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    push_exp(32'h200, 8);
    mon_en = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.inst_valid !== 1'b1 || bus.imem_req_valid !== 1'b0) begin
      n_mis++;
      $display("FAIL collide_cycle: got inst_valid=%b req=%b, want inst_valid=1 req=0",
               bus.inst_valid, bus.imem_req_valid);
    end
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (dut.drop_cnt_q !== 2'd0) begin
      n_mis++; $display("FAIL collide_drop: got %0d, want 0", dut.drop_cnt_q);
    end
    n_cmp++;
    if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== 32'h200) begin
      n_mis++;
      $display("FAIL collide_req: got valid=%b addr=%h, want valid=1 addr=00000200",
               bus.imem_req_valid, bus.imem_req_addr);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) next_cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL collide_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_wrap();
    logic [31:0] want;
    do_reset(1, 1'b0);
    bus.inst_ready = 1'b1;
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    push_exp(32'hFFFF_FFF8, 5);
    mon_en = 1'b1;
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      want = 32'hFFFF_FFF8 + 32'(4 * i);
      @(negedge clk);
      n_cmp++;
      if (bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== want) begin
        n_mis++;
        $display("FAIL wrap_req[%0d]: got valid=%b addr=%h, want valid=1 addr=%h",
                 i, bus.imem_req_valid, bus.imem_req_addr, want);
      end
      next_cycle();
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) next_cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL wrap_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  task automatic test_misalign();
    logic [31:0] target;
    do_reset(1, 1'b0);
    bus.inst_ready = 1'b1;
    repeat (4) next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
`ifdef FETCH_MISALIGN_CHECK_EN
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (misalign !== 1'b1 || bus.imem_req_valid !== 1'b0 || bus.inst_valid !== 1'b0) begin
        n_mis++;
        $display("FAIL mis_halt[%0d]: got mis=%b req=%b inst=%b, want 1 0 0",
                 i, misalign, bus.imem_req_valid, bus.inst_valid);
      end
      next_cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0200;
    target         = 32'h0000_0200;
`else
    target = 32'h0000_0100;
`endif
    push_exp(target, 6);
    mon_en = 1'b1;
    next_cycle();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (misalign !== 1'b0 || bus.imem_req_valid !== 1'b1 || bus.imem_req_addr !== target) begin
      n_mis++;
      $display("FAIL mis_resume: got mis=%b req=%b addr=%h, want mis=0 req=1 addr=%h",
               misalign, bus.imem_req_valid, bus.imem_req_addr, target);
    end
    for (int k = 0; k < 40 && exp_q.size() != 0; k++) next_cycle();
    mon_en = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_mis++; $display("FAIL mis_drain: got %0d left, want 0", exp_q.size());
    end
  endtask

  initial begin
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    bus.inst_ready     = 1'b0;
    bus.imem_req_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_collide();
    test_wrap();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
